// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared word, arbiter-state and RAM-status types
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic {IDLE, BUSY} arb_state_t;
  typedef enum logic [1:0] {RAM_FREE, RAM_BUSY, RAM_ACCESS, RAM_ERROR} ramstate_t;
endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: core-side request/wait signals and the single RAM port
//   master modport: arbiter side (takes core requests, drives waits and RAM strobes)
//   slave modport:  environment side (cores and RAM model)
//   grant_cnt exists only when ARB_STATS_EN is defined
interface ram_arbiter_if #(
  parameter int CPUS = 2,
  parameter int WORD_W = 32
);
  import cpu_types_pkg::*;
  logic [CPUS-1:0] iREN, dREN, dWEN, iwait, dwait;
  logic [CPUS*WORD_W-1:0] iaddr, daddr, dstore, iload, dload;
  logic ramREN, ramWEN;
  logic [WORD_W-1:0] ramaddr, ramstore, ramload;
  ramstate_t ramstate;
`ifdef ARB_STATS_EN
  logic [2*CPUS*16-1:0] grant_cnt;
`endif
  modport master (
    input iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
`ifdef ARB_STATS_EN
    , output grant_cnt
`endif
  );
  modport slave (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
`ifdef ARB_STATS_EN
    , input grant_cnt
`endif
  );
endinterface

// File: rtl/rr_picker.sv
// rr_picker: first set request scanning ptr, ptr+1, ... modulo N
//   req in N, ptr in clog2(N); idx out clog2(N), valid out 1
module rr_picker #(
  parameter int N = 4,
  localparam int PW = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] idx,
  output logic          valid
);
  // Scan backwards so the last hit written is the one nearest ptr.
  always_comb begin
    idx = '0;
    valid = |req;
    for (int i = N - 1; i >= 0; i--)
      if (req[(int'(ptr) + i) % N]) idx = PW'((int'(ptr) + i) % N);
  end
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin sharing of one RAM port among CPUS instruction/data ports
//   CLK, RST (sync, active-high); bus: ram_arbiter_if.master
//   source 2c = data port of core c, source 2c+1 = instruction port of core c
//   optional ARB_STATS_EN adds bus.grant_cnt, a saturating 16-bit completion count per source
module ram_arbiter
  import cpu_types_pkg::*;
#(
  parameter int CPUS = 2,
  parameter int WORD_W = 32
) (
  input logic CLK,
  input logic RST,
  ram_arbiter_if.master bus
);
  localparam int NS = 2 * CPUS;
  localparam int SW = $clog2(NS);
  arb_state_t state;
  logic [NS-1:0] req;
  logic [SW-1:0] rr_ptr, grant, pick;
  logic pick_v, busy, gdata, done;
  int gc;
  for (genvar c = 0; c < CPUS; c++) begin : g_req
    assign req[2*c] = bus.dREN[c] | bus.dWEN[c];
    assign req[2*c+1] = bus.iREN[c];
  end
  rr_picker #(.N(NS)) u_pick (.req(req), .ptr(rr_ptr), .idx(pick), .valid(pick_v));
  assign busy = state == BUSY;
  assign gc = int'(grant >> 1);
  assign gdata = ~grant[0];
  // A completion needs the granted request still standing; a dropped request is an abort.
  assign done = busy && req[grant] && bus.ramstate == RAM_ACCESS;
  assign bus.iload = {CPUS{bus.ramload}};
  assign bus.dload = {CPUS{bus.ramload}};
  always_comb begin
    bus.iwait = '1;
    bus.dwait = '1;
    bus.ramaddr = '0;
    bus.ramstore = '0;
    bus.ramREN = 1'b0;
    bus.ramWEN = 1'b0;
    if (busy) begin
      bus.ramaddr = gdata ? bus.daddr[gc*WORD_W +: WORD_W] : bus.iaddr[gc*WORD_W +: WORD_W];
      bus.ramstore = gdata ? bus.dstore[gc*WORD_W +: WORD_W] : '0;
      bus.ramWEN = gdata & bus.dWEN[gc];
      bus.ramREN = gdata ? bus.dREN[gc] & ~bus.dWEN[gc] : bus.iREN[gc];
    end
    if (done && gdata) bus.dwait[gc] = 1'b0;
    if (done && !gdata) bus.iwait[gc] = 1'b0;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      rr_ptr <= '0;
      grant <= '0;
    end else if (!busy) begin
      if (pick_v) begin
        grant <= pick;
        state <= BUSY;
      end
    end else if (!req[grant]) begin
      state <= IDLE;
    end else if (done) begin
      state <= IDLE;
      rr_ptr <= grant == SW'(NS - 1) ? '0 : grant + SW'(1);
    end
  end
`ifdef ARB_STATS_EN
  for (genvar s = 0; s < NS; s++) begin : g_cnt
    logic [15:0] cnt;
    always_ff @(posedge CLK) begin
      if (RST) cnt <= '0;
      else if (done && grant == SW'(s) && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
    end
    assign bus.grant_cnt[s*16 +: 16] = cnt;
  end
`endif
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed vector bench for ram_arbiter with CPUS=2
module tb_ram_arbiter;
  import cpu_types_pkg::*;
  typedef struct {
    logic rst;
    logic [1:0] iren, dren, dwen;
    ramstate_t rs;
    logic [1:0] iw, dw;
    logic ren, wen;
    word_t addr, store;
  } vec_t;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int checks = 0;
  int failures = 0;
  vec_t tbl[$];
  ram_arbiter_if #(.CPUS(2), .WORD_W(32)) bus ();
  ram_arbiter #(.CPUS(2), .WORD_W(32)) dut (.CLK(CLK), .RST(RST), .bus(bus));
  always #5 CLK = ~CLK;
  function automatic vec_t v(logic r, logic [1:0] ir, dr, dw, ramstate_t rs,
                             logic [1:0] iw, dwt, logic ren, wen, word_t a, st);
    vec_t x;
    x.rst = r; x.iren = ir; x.dren = dr; x.dwen = dw; x.rs = rs;
    x.iw = iw; x.dw = dwt; x.ren = ren; x.wen = wen; x.addr = a; x.store = st;
    return x;
  endfunction
  function automatic vec_t idle(logic [1:0] ir, dr, dw, ramstate_t rs);
    return v(1'b0, ir, dr, dw, rs, 2'b11, 2'b11, 1'b0, 1'b0, 32'h0, 32'h0);
  endfunction
  task automatic chk(string nm, int id, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s step%0d got=%h exp=%h", nm, id, got, exp);
    end
  endtask
  task automatic apply(vec_t x, int id);
    @(negedge CLK);
    RST = x.rst;
    bus.iREN = x.iren;
    bus.dREN = x.dren;
    bus.dWEN = x.dwen;
    bus.ramstate = x.rs;
    #1;
    chk("iwait", id, 64'(bus.iwait), 64'(x.iw));
    chk("dwait", id, 64'(bus.dwait), 64'(x.dw));
    chk("ramREN", id, 64'(bus.ramREN), 64'(x.ren));
    chk("ramWEN", id, 64'(bus.ramWEN), 64'(x.wen));
    chk("ramaddr", id, 64'(bus.ramaddr), 64'(x.addr));
    chk("ramstore", id, 64'(bus.ramstore), 64'(x.store));
    chk("iload", id, bus.iload, {2{32'h12345678}});
    chk("dload", id, bus.dload, {2{32'h12345678}});
  endtask
  initial begin
    bus.iREN = '0; bus.dREN = '0; bus.dWEN = '0; bus.ramstate = RAM_FREE;
    bus.iaddr = {32'h100, 32'h200};
    bus.daddr = {32'h80, 32'h40};
    bus.dstore = {32'hCAFEF00D, 32'hDEADBEEF};
    bus.ramload = 32'h12345678;
    repeat (2) @(posedge CLK);
    for (int i = 0; i < 10; i++) tbl.push_back(idle(0, 0, 0, RAM_FREE));
    // single data write to core 0, ERROR in the middle must hold the grant
    tbl.push_back(idle(0, 0, 1, RAM_FREE));
    tbl.push_back(v(0, 0, 0, 1, RAM_BUSY, 3, 3, 0, 1, 32'h40, 32'hDEADBEEF));
    tbl.push_back(v(0, 0, 0, 1, RAM_ERROR, 3, 3, 0, 1, 32'h40, 32'hDEADBEEF));
    tbl.push_back(v(0, 0, 0, 1, RAM_ACCESS, 3, 2, 0, 1, 32'h40, 32'hDEADBEEF));
    tbl.push_back(idle(0, 0, 0, RAM_FREE));
    // instruction read of core 1
    tbl.push_back(idle(2, 0, 0, RAM_FREE));
    tbl.push_back(v(0, 2, 0, 0, RAM_BUSY, 3, 3, 1, 0, 32'h100, 32'h0));
    tbl.push_back(v(0, 2, 0, 0, RAM_ACCESS, 1, 3, 1, 0, 32'h100, 32'h0));
    tbl.push_back(idle(0, 0, 0, RAM_FREE));
    // abort of dREN[1]; rr_ptr stays 0 so s1 wins over s3
    tbl.push_back(idle(0, 2, 0, RAM_FREE));
    tbl.push_back(v(0, 3, 2, 0, RAM_BUSY, 3, 3, 1, 0, 32'h80, 32'hCAFEF00D));
    tbl.push_back(v(0, 3, 0, 0, RAM_BUSY, 3, 3, 0, 0, 32'h80, 32'hCAFEF00D));
    tbl.push_back(idle(3, 0, 0, RAM_FREE));
    tbl.push_back(v(0, 3, 0, 0, RAM_ACCESS, 2, 3, 1, 0, 32'h200, 32'h0));
    tbl.push_back(idle(2, 0, 0, RAM_FREE));
    tbl.push_back(v(0, 2, 0, 0, RAM_ACCESS, 1, 3, 1, 0, 32'h100, 32'h0));
    tbl.push_back(idle(0, 0, 0, RAM_FREE));
    // all four sources, ACCESS on every BUSY cycle: order s0,s1,s2,s3,s0
    tbl.push_back(idle(3, 3, 0, RAM_ACCESS));
    tbl.push_back(v(0, 3, 3, 0, RAM_ACCESS, 3, 2, 1, 0, 32'h40, 32'hDEADBEEF));
    tbl.push_back(idle(3, 3, 0, RAM_ACCESS));
    tbl.push_back(v(0, 3, 3, 0, RAM_ACCESS, 2, 3, 1, 0, 32'h200, 32'h0));
    tbl.push_back(idle(3, 3, 0, RAM_ACCESS));
    tbl.push_back(v(0, 3, 3, 0, RAM_ACCESS, 3, 1, 1, 0, 32'h80, 32'hCAFEF00D));
    tbl.push_back(idle(3, 3, 0, RAM_ACCESS));
    tbl.push_back(v(0, 3, 3, 0, RAM_ACCESS, 1, 3, 1, 0, 32'h100, 32'h0));
    tbl.push_back(idle(3, 3, 0, RAM_ACCESS));
    tbl.push_back(v(0, 3, 3, 0, RAM_ACCESS, 3, 2, 1, 0, 32'h40, 32'hDEADBEEF));
    tbl.push_back(idle(0, 0, 0, RAM_FREE));
    foreach (tbl[i]) apply(tbl[i], i);
    // reset mid-BUSY after moving rr_ptr to 3
    apply(idle(0, 0, 2, RAM_FREE), 100);
    apply(v(0, 0, 0, 2, RAM_ACCESS, 3, 1, 0, 1, 32'h80, 32'hCAFEF00D), 101);
    apply(idle(0, 0, 2, RAM_FREE), 102);
`ifdef ARB_STATS_EN
    chk("grant_cnt", 102, bus.grant_cnt, {16'd3, 16'd2, 16'd2, 16'd3});
`endif
    apply(v(1, 0, 0, 2, RAM_BUSY, 3, 3, 0, 1, 32'h80, 32'hCAFEF00D), 103);
    apply(idle(2, 0, 1, RAM_FREE), 104);
`ifdef ARB_STATS_EN
    chk("grant_cnt_rst", 104, bus.grant_cnt, 64'h0);
`endif
    // rr_ptr back at 0 picks s0 over s3
    apply(v(0, 2, 0, 1, RAM_BUSY, 3, 3, 0, 1, 32'h40, 32'hDEADBEEF), 105);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
